activation_lut: RTL and testbench

ACTIVATION_LUT -- requirements
Module: activation_lut

---
 rtl/activation_lut.sv | 91 +++++++++
 tb/tb_activation_lut.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/activation_lut.sv
// rtl/activation_lut.sv - self-initialising activation lookup table with a 2-stage valid/ready read pipeline
// Optional ACT_WRITE_EN: adds a run-time table write port (wr_en/wr_addr/wr_data).
module activation_lut #(
  parameter int DW = 8,
  parameter int AW = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [AW-1:0] in_addr,
  input  logic          in_mirror,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [DW-1:0] out_data,
`ifdef ACT_WRITE_EN
  input  logic          wr_en,
  input  logic [AW-1:0] wr_addr,
  input  logic [DW-1:0] wr_data,
`endif
  output logic          busy
);

  localparam logic [0:0] INIT = 1'b0;
  localparam logic [0:0] RUN  = 1'b1;

  logic [0:0]    state;
  logic [AW-1:0] init_cnt;
  logic [DW-1:0] table_mem [2**AW];

  logic          s1_valid;
  logic [AW-1:0] s1_addr;
  logic          advance;
  logic [AW-1:0] eff_addr;

  // Inverted counter MSB-aligned into DW: pad with zeros or drop LSBs as widths dictate.
  logic [AW+DW-1:0] def_ext;
  logic [DW-1:0]    def_entry;

  assign def_ext   = {~init_cnt, {DW{1'b0}}};
  assign def_entry = def_ext[AW+DW-1 -: DW];

  assign busy     = (state == INIT);
  assign advance  = !out_valid || out_ready;
  assign in_ready = (state == RUN) && advance;
  assign eff_addr = in_mirror ? ~in_addr : in_addr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= INIT;
      init_cnt <= '0;
    end else if (state == INIT) begin
      init_cnt <= init_cnt + 1'b1;
      if (&init_cnt) begin
        state <= RUN;
      end
    end
  end

  // Table storage is not reset; INIT rewrites every entry after each reset.
  always_ff @(posedge clk) begin
    if (state == INIT) begin
      table_mem[init_cnt] <= def_entry;
    end
`ifdef ACT_WRITE_EN
    else if (wr_en) begin
      table_mem[wr_addr] <= wr_data;
    end
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid  <= 1'b0;
      s1_addr   <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
    end else if (advance) begin
      s1_valid  <= in_valid && in_ready;
      if (in_valid && in_ready) begin
        s1_addr <= eff_addr;
      end
      out_valid <= s1_valid;
      // Read sees the pre-edge table contents, so a same-edge write returns the old entry.
      if (s1_valid) begin
        out_data <= table_mem[s1_addr];
      end
    end
  end

endmodule

// File: tb/tb_activation_lut.sv
// tb/tb_activation_lut.sv - scoreboard testbench for activation_lut (DW=AW=8)
module tb_activation_lut;

  logic       clk;
  logic       rst_n;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] in_addr;
  logic       in_mirror;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] out_data;
  logic       busy;
`ifdef ACT_WRITE_EN
  logic       wr_en;
  logic [7:0] wr_addr;
  logic [7:0] wr_data;
`endif

  int checks;
  int failures;
  int accepted;
  logic [7:0] exp_q [$];

  activation_lut #(.DW(8), .AW(8)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_addr   (in_addr),
    .in_mirror (in_mirror),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
`ifdef ACT_WRITE_EN
    .wr_en     (wr_en),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
`endif
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", name, act, req);
    end
  endtask

  // Monitor: pops one expectation per output handshake, sampled mid-cycle.
  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        check("unexpected_output", {24'd0, out_data}, 32'hFFFF_FFFF);
      end else begin
        check("scoreboard_data", {24'd0, out_data}, {24'd0, exp_q.pop_front()});
      end
    end
  end

  task automatic issue(input logic [7:0] a, input logic m, input logic [7:0] e, input bit push);
    bit ok;
    ok = 1'b0;
    in_valid  = 1'b1;
    in_addr   = a;
    in_mirror = m;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (in_ready) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) check("accept_timeout", 32'd0, 32'd1);
    else begin
      accepted++;
      if (push) exp_q.push_back(e);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    in_valid  = 1'b0;
    in_mirror = 1'b0;
  endtask

  task automatic drain();
    for (int i = 0; i < 50 && exp_q.size() != 0; i++) @(negedge clk);
    check("queue_drained", exp_q.size(), 32'd0);
    @(posedge clk);
    #1;
  endtask

  task automatic wait_init(output int cycles, output int bad_ready);
    cycles    = 0;
    bad_ready = 0;
    for (int i = 0; i < 1000; i++) begin
      @(negedge clk);
      if (!busy) break;
      cycles++;
      if (in_ready) bad_ready++;
    end
  endtask

  initial begin
    int cyc;
    int bad;
    checks    = 0;
    failures  = 0;
    accepted  = 0;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_addr   = '0;
    in_mirror = 1'b0;
    out_ready = 1'b1;
`ifdef ACT_WRITE_EN
    wr_en     = 1'b0;
    wr_addr   = '0;
    wr_data   = '0;
`endif
    repeat (3) @(posedge clk);
    #1;
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_out_data", out_data, 8'd0);
    check("rst_in_ready", in_ready, 1'b0);
    check("rst_busy", busy, 1'b1);

    rst_n = 1'b1;
    wait_init(cyc, bad);
    check("init_busy_cycles", cyc, 32'd256);
    check("init_in_ready_low", bad, 32'd0);
    check("run_in_ready", in_ready, 1'b1);
    @(posedge clk);
    #1;

    // Latency: accepted at edge E, out_valid appears after E+1.
    issue(8'd0, 1'b0, 8'd255, 1'b1);
    idle();
    @(negedge clk);
    check("latency_stage1_no_valid", out_valid, 1'b0);
    @(negedge clk);
    check("latency_stage2_valid", out_valid, 1'b1);
    check("latency_stage2_data", out_data, 8'd255);
    drain();

    issue(8'd0,   1'b0, 8'd255, 1'b1);
    issue(8'd127, 1'b0, 8'd128, 1'b1);
    issue(8'd255, 1'b0, 8'd0,   1'b1);
    idle();
    drain();

    issue(8'd255, 1'b1, 8'd255, 1'b1);
    issue(8'd0,   1'b1, 8'd0,   1'b1);
    issue(8'd3,   1'b0, 8'd252, 1'b1);
    idle();
    drain();

    // Backpressure: only two lookups fit while the output is held.
    out_ready = 1'b0;
    accepted  = 0;
    fork
      begin
        issue(8'd10, 1'b0, 8'd245, 1'b1);
        issue(8'd11, 1'b0, 8'd244, 1'b1);
        issue(8'd12, 1'b0, 8'd243, 1'b1);
        idle();
      end
      begin
        @(negedge clk);
        @(negedge clk);
        for (int i = 0; i < 3; i++) begin
          @(negedge clk);
          check("stall_out_valid", out_valid, 1'b1);
          check("stall_out_data", out_data, 8'd245);
        end
        check("stall_accepts", accepted, 32'd2);
        check("stall_in_ready", in_ready, 1'b0);
        @(posedge clk);
        #1;
        out_ready = 1'b1;
      end
    join
    drain();

`ifdef ACT_WRITE_EN
    issue(8'd3, 1'b0, 8'd252, 1'b1);
    wr_en   = 1'b1;
    wr_addr = 8'd3;
    wr_data = 8'h5A;
    issue(8'd3, 1'b0, 8'h5A, 1'b1);
    wr_en   = 1'b0;
    issue(8'd3, 1'b0, 8'h5A, 1'b1);
    idle();
    drain();
`endif

    // Reset with two lookups in flight; results must be discarded.
    out_ready = 1'b0;
    issue(8'd5, 1'b0, 8'd250, 1'b0);
    issue(8'd6, 1'b0, 8'd249, 1'b0);
    idle();
    check("inflight_out_valid", out_valid, 1'b1);
    rst_n = 1'b0;
    #1;
    check("midrst_out_valid", out_valid, 1'b0);
    check("midrst_out_data", out_data, 8'd0);
    check("midrst_in_ready", in_ready, 1'b0);
    check("midrst_busy", busy, 1'b1);
    @(posedge clk);
    #1;
    rst_n     = 1'b1;
    out_ready = 1'b1;
    wait_init(cyc, bad);
    check("reinit_busy_cycles", cyc, 32'd256);
    @(posedge clk);
    #1;
    issue(8'd3, 1'b0, 8'd252, 1'b1);
    idle();
    drain();
    repeat (3) @(negedge clk);
    check("no_stray_output", out_valid, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
